// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_e    : operation codes carried on the 3-bit `op` input
//   md_state_e : sequencer states
//   DATA_W     : architectural register width
package muldiv_hilo_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_hilo_ctrl_div_step.sv
// One combinational restoring-division iteration.
//   rem       : 33-bit partial remainder
//   quo       : quotient register; its MSB is the next dividend bit
//   dvs       : divisor magnitude
//   rem_next  : remainder after this iteration
//   quo_next  : quotient shifted left with the new quotient bit
module muldiv_hilo_ctrl_div_step
  import muldiv_hilo_ctrl_pkg::*;
(
  input  logic [DATA_W:0]   rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W:0]   rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            fits;

  assign shifted  = {rem[DATA_W-1:0], quo[DATA_W-1]};
  // Compare at full width so the trial subtraction never needs a borrow bit.
  assign fits     = ({rem, quo[DATA_W-1]} >= {2'b00, dvs});
  assign diff     = shifted - {1'b0, dvs};
  assign rem_next = fits ? diff : shifted;
  assign quo_next = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle multiply/divide sequencer owning architectural HI/LO.
//   clk, rst     : clock, asynchronous active-high reset
//   start, op    : HI/LO-class instruction present in EXE and its operation
//   src_a, src_b : forwarded rs / rt operands
//   flush        : cancels the instruction in EXE and any in-flight operation
//   stall        : freeze the front of the pipeline this cycle
//   hi, lo       : architectural HI/LO registers
//   busy         : sequencer not idle
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  md_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              hi_we, lo_we;
  logic [DATA_W-1:0] hi_nx, lo_nx;

  logic signed [DATA_W:0]     mul_a_p0, mul_b_p0;
  logic [DATA_W:0]            rem_p0;
  logic [DATA_W-1:0]          quo_p0, dvs_p0;
  logic                       sign_q_p0, sign_r_p0, is_div_p0;
  logic signed [2*DATA_W-1:0] mul_a_ext, mul_b_ext, prod_full;
  logic [2*DATA_W-1:0]        prod_p1;
  logic [DATA_W:0]            rem_step;
  logic [DATA_W-1:0]          quo_step;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state == S_IDLE) && start && !flush;
  assign busy   = (state != S_IDLE);

  // ---- stage p0: operand capture and iterative divide ----
  muldiv_hilo_ctrl_div_step u_div_step (
    .rem      (rem_p0),
    .quo      (quo_p0),
    .dvs      (dvs_p0),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      case (op)
        MD_MULT: begin
          mul_a_p0  <= {src_a[DATA_W-1], src_a};
          mul_b_p0  <= {src_b[DATA_W-1], src_b};
          is_div_p0 <= 1'b0;
        end
        MD_MULTU: begin
          mul_a_p0  <= {1'b0, src_a};
          mul_b_p0  <= {1'b0, src_b};
          is_div_p0 <= 1'b0;
        end
        MD_DIV: begin
          quo_p0    <= magnitude(src_a);
          dvs_p0    <= magnitude(src_b);
          sign_q_p0 <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
          sign_r_p0 <= src_a[DATA_W-1];
          rem_p0    <= '0;
          is_div_p0 <= 1'b1;
        end
        MD_DIVU: begin
          quo_p0    <= src_a;
          dvs_p0    <= src_b;
          sign_q_p0 <= 1'b0;
          sign_r_p0 <= 1'b0;
          rem_p0    <= '0;
          is_div_p0 <= 1'b1;
        end
        default: ;
      endcase
    end else if (state == S_DIV) begin
      rem_p0 <= rem_step;
      quo_p0 <= quo_step;
    end
    if (state == S_MUL) begin
      prod_p1 <= prod_full;
    end
  end

  // ---- stage p1: product registered across MUL -> FIX ----
  // Operands are already sign/zero extended to 33 bits; widening them to 64
  // keeps the low 64 product bits exact for both signed and unsigned ops.
  assign mul_a_ext = {{(DATA_W-1){mul_a_p0[DATA_W]}}, mul_a_p0};
  assign mul_b_ext = {{(DATA_W-1){mul_b_p0[DATA_W]}}, mul_b_p0};
  assign prod_full = mul_a_ext * mul_b_ext;

  // ---- control: next state, stall and HI/LO write enables ----
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_nx = S_MUL;
              stall    = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_nx = S_DIV;
              stall    = 1'b1;
            end
            MD_MTHI: begin
              hi_we = 1'b1;
              hi_nx = src_a;
            end
            MD_MTLO: begin
              lo_we = 1'b1;
              lo_nx = src_a;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        stall    = 1'b1;
        state_nx = S_FIX;
      end
      S_DIV: begin
        stall = 1'b1;
        if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
          state_nx = S_FIX;
        end
      end
      S_FIX: begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_nx    = is_div_p0 ? apply_sign(rem_p0[DATA_W-1:0], sign_r_p0)
                             : prod_p1[2*DATA_W-1:DATA_W];
        lo_nx    = is_div_p0 ? apply_sign(quo_p0, sign_q_p0)
                             : prod_p1[DATA_W-1:0];
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // A flush overrides everything: no acceptance, no stall, no write.
    if (flush) begin
      state_nx = S_IDLE;
      stall    = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
    end
  end

  // ---- stage p2: architectural state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_DIV && state_nx == S_DIV) ? cnt + CNT_W'(1) : '0;
      if (hi_we) hi <= hi_nx;
      if (lo_we) lo <= lo_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: the driver computes expected HI/LO
// and stall counts with plain arithmetic and queues them; a monitor counts
// stall cycles per instruction and compares once the instruction leaves EXE.
module tb_muldiv_hilo_ctrl;
  import muldiv_hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall;
  logic [31:0] hi, lo;
  logic        busy;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.DIV_CYCLES(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .stall (stall),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          id_ctr = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          mon_cnt = 0;
  int          mon_done = 0;
  bit          mon_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1. Holds start until the instruction leaves EXE;
  // flush_at >= 0 asserts flush in that cycle of the instruction.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int exp_stalls);
    exp_t            e;
    longint          sa, sbv, p, q, r;
    longint unsigned up;
    bit              left;
    int              i;
    if (flush_at < 0) begin
      case (o)
        MD_MULT: begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          p = sa * sbv;
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        MD_MULTU: begin
          up = {32'b0, a} * {32'b0, b};
          m_hi = up[63:32]; m_lo = up[31:0];
        end
        MD_DIV: begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          q = sa / sbv; r = sa % sbv;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        MD_DIVU: begin
          if (b == 0) begin
            m_lo = 32'hFFFF_FFFF; m_hi = a;
          end else begin
            m_lo = a / b; m_hi = a % b;
          end
        end
        MD_MTHI: m_hi = a;
        MD_MTLO: m_lo = a;
        default: ;
      endcase
    end
    e.hi = m_hi; e.lo = m_lo; e.stalls = exp_stalls; e.id = id_ctr;
    id_ctr++;
    exp_q.push_back(e);

    start = 1'b1; op = o; src_a = a; src_b = b;
    left = 1'b0;
    i = 0;
    while (!left && i < 100) begin
      flush = (i == flush_at);
      #1;
      if (!stall) left = 1'b1;
      else begin
        @(posedge clk); #1;
        i++;
      end
    end
    if (!left) begin
      total++; bad++;
      $display("FAIL timeout#%0d actual=stall_held required=release", e.id);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    if (flush_at >= 0) check($sformatf("idle_after_flush#%0d", e.id), busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_cnt  = 0;
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        mon_pend = 1'b0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion actual=hi %h lo %h required=none", hi, lo);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("hi#%0d", mon_e.id), hi, mon_e.hi);
          check($sformatf("lo#%0d", mon_e.id), lo, mon_e.lo);
          check($sformatf("stalls#%0d", mon_e.id), mon_done, mon_e.stalls);
        end
      end
      if (start) begin
        if (stall) mon_cnt++;
        else begin
          mon_done = mon_cnt;
          mon_cnt  = 0;
          mon_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          es;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_stall", stall, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(MD_MULT,  32'hFFFF_FFFE, 32'h3, -1, 2);
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'h3, -1, 2);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'h2, -1, 33);
    issue(MD_DIVU,  32'd100, 32'd7, -1, 33);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 33);
    issue(MD_DIVU,  32'h1234, 32'h0, -1, 33);
    issue(MD_MTHI,  32'hDEAD_BEEF, 32'h0, -1, 0);
    issue(MD_MTLO,  32'h0BAD_F00D, 32'h0, -1, 0);
    issue(MD_DIV,   32'h1234_5678, 32'h3, 11, 11);
    issue(MD_MULT,  32'd7, 32'd9, 2, 2);
    issue(MD_MULT,  32'd7, 32'd9, 0, 0);

    // Reset in the middle of a divide.
    start = 1'b1; op = MD_DIV; src_a = 32'h0000_1000; src_b = 32'h7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(MD_MULTU, 32'd3, 32'd5, -1, 2);

    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 15));
        default: ;
      endcase
      if (ro == MD_DIV && rb == 0) rb = 32'd1;
      case (ro)
        MD_MULT, MD_MULTU: es = 2;
        MD_DIV, MD_DIVU:   es = 33;
        default:           es = 0;
      endcase
      issue(ro, ra, rb, -1, es);
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
